// File: rtl/num_parse_arbiter.sv
`default_nettype none
// num_parse_arbiter: shares one ASCII-decimal parser between N_CH byte streams and tags each number with its source ID.
// Optional macro NUM_ARB_TIMEOUT_EN: forces a delimiter after TIMEOUT_CYC idle owner cycles.
module num_parse_arbiter #(
    parameter int N_CH        = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8*N_CH-1:0] s_dtm,
    input  logic [N_CH-1:0]   s_vld,
    output logic [N_CH-1:0]   s_rdy,
    output logic [7:0]        p_s_dtm,
    output logic              p_s_vld,
    input  logic              p_s_rdy,
    input  logic [31:0]       p_n_dtm,
    input  logic              p_n_vld,
    output logic              p_n_rdy,
    output logic [31:0]       n_dtm,
    output logic [ID_W-1:0]   n_id,
    output logic              n_vld,
    input  logic              n_rdy
);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [2:0] {
        FLUSH  = 3'd0,
        FLUSH2 = 3'd1,
        IDLE   = 3'd2,
        LOCKED = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t          state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] grant_nxt;
    logic            pick_found;
    logic [N_CH-1:0] is_dig;
    logic [N_CH-1:0] own_sel;
    logic [7:0]      own_dtm;
    logic            own_vld;
    logic            own_dig;
    logic            inject;

    if (N_CH < 2 || N_CH > 16 || (1 << ID_W) < N_CH || TIMEOUT_CYC < 2) begin : g_param_check
        $error("num_parse_arbiter: illegal N_CH/ID_W/TIMEOUT_CYC combination");
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign is_dig[c]  = (s_dtm[8*c +: 8] >= 8'h30) && (s_dtm[8*c +: 8] <= 8'h39);
        assign own_sel[c] = (grant == ID_W'(c));
    end

    always_comb begin
        own_dtm = '0;
        own_vld = 1'b0;
        own_dig = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (own_sel[c]) begin
                own_dtm = s_dtm[8*c +: 8];
                own_vld = s_vld[c];
                own_dig = is_dig[c];
            end
        end
    end

    // First digit-presenting channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick       = '0;
        for (int k = 0; k < N_CH; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_CH) begin
                j = j - N_CH;
            end
            if (!pick_found && s_vld[j] && is_dig[j]) begin
                pick_found = 1'b1;
                pick       = ID_W'(j);
            end
        end
    end

    assign grant_nxt = (grant == ID_W'(N_CH - 1)) ? '0 : grant + 1'b1;

`ifdef NUM_ARB_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMR_W-1:0] timer;
    assign inject = (state == LOCKED) && (timer == TMR_W'(TIMEOUT_CYC - 1));
`else
    assign inject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FLUSH;
            grant  <= '0;
            rr_ptr <= '0;
`ifdef NUM_ARB_TIMEOUT_EN
            timer  <= '0;
`endif
        end else begin
            case (state)
                FLUSH: begin
                    if (p_s_rdy) begin
                        state <= FLUSH2;
                    end
                end
                FLUSH2: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick;
                        state <= LOCKED;
`ifdef NUM_ARB_TIMEOUT_EN
                        timer <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (inject) begin
                        if (p_s_rdy) begin
                            state <= DRAIN;
                        end
                    end else if (own_vld && p_s_rdy && !own_dig) begin
                        state <= DRAIN;
                    end
`ifdef NUM_ARB_TIMEOUT_EN
                    if (!inject) begin
                        if (own_vld && p_s_rdy) begin
                            timer <= '0;
                        end else if (!own_vld) begin
                            timer <= timer + 1'b1;
                        end
                    end
`endif
                end
                DRAIN: begin
                    if (p_n_vld && n_rdy) begin
                        rr_ptr <= grant_nxt;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= FLUSH;
                end
            endcase
        end
    end

    // The parser has no reset of its own, so every stream-facing handshake is held off until the flush completes.
    always_comb begin
        s_rdy   = '0;
        p_s_dtm = SPACE;
        p_s_vld = 1'b0;
        p_n_rdy = 1'b0;
        n_vld   = 1'b0;
        case (state)
            FLUSH: begin
                p_s_vld = 1'b1;
                p_n_rdy = 1'b1;
            end
            FLUSH2: begin
                p_n_rdy = 1'b1;
            end
            IDLE: begin
                s_rdy = s_vld & ~is_dig;
            end
            LOCKED: begin
                if (inject) begin
                    p_s_vld = 1'b1;
                end else begin
                    p_s_dtm = own_dtm;
                    p_s_vld = own_vld;
                    s_rdy   = own_sel & {N_CH{p_s_rdy}};
                end
            end
            DRAIN: begin
                n_vld   = p_n_vld;
                p_n_rdy = n_rdy;
            end
            default: begin
                s_rdy = '0;
            end
        endcase
        if (rst) begin
            s_rdy = '0;
            n_vld = 1'b0;
        end
    end

    assign n_dtm = p_n_dtm;
    assign n_id  = grant;

endmodule
`default_nettype wire

// File: doc/num_parse_arbiter.md
Name: num_parse_arbiter

Overview:
Shares one str_to_num ASCII-decimal parser, instantiated by the parent, between N_CH independent byte-stream requesters, e.g. several UART RX channels. A requester is granted on the first digit of a number and holds the parser until its delimiter has passed and the parsed number has left.
Leading non-digit bytes are consumed and dropped locally, so they never occupy the parser. Each output number carries the ID of its source channel.
On reset, the block flushes the parser, which itself has no reset, to a known idle state.

Parameters:
N_CH, 4, number of requester channels (2..16)
ID_W, 2, width of channel ID; must satisfy 2**ID_W >= N_CH
TIMEOUT_CYC, 1024, idle cycles before a forced delimiter (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
s_dtm  in  8*N_CH  channel c byte on bits [8c+7:8c]
s_vld  in  N_CH  per-channel byte valid
s_rdy  out  N_CH  per-channel byte ready
p_s_dtm  out  8  byte to parser
p_s_vld  out  1  parser byte valid
p_s_rdy  in  1  parser byte ready
p_n_dtm  in  32  parser number
p_n_vld  in  1  parser number valid
p_n_rdy  out  1  parser number ready
n_dtm  out  32  number out; combinational pass-through of p_n_dtm
n_id  out  ID_W  source channel of n_dtm (registered grant)
n_vld  out  1  number valid
n_rdy  in  1  number ready

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Digit definition: byte value 0x30..0x39.
- Handshakes: a transfer occurs when vld && rdy are both high at a clk edge. vld, once raised, is not dropped by the source before the transfer.
- Reset: state<=FLUSH, grant<=0, rr_ptr<=0, timer<=0. During reset and in FLUSH/FLUSH2, all s_rdy=0 and n_vld=0.
- FLUSH: p_s_dtm=0x20, p_s_vld=1, p_n_rdy=1 (any parser output is discarded). Move to FLUSH2 on p_s_vld&&p_s_rdy.
- FLUSH2: exactly one cycle, p_s_vld=0, p_n_rdy=1 (discards a number produced by the flush). Then go to IDLE.
- IDLE:
  - p_s_vld=0, p_n_rdy=0.
  - Every channel with s_vld=1 and a non-digit byte sees s_rdy=1; its byte is dropped. Several channels may drop in the same cycle.
  - Channels presenting a digit see s_rdy=0.
  - If any channel presents a digit, pick the first one at or after rr_ptr, wrapping modulo N_CH. Register it as grant and go to LOCKED.
  - No byte is forwarded in the IDLE cycle, so grant-to-forward latency is 1 cycle.
- LOCKED:
  - p_s_dtm=s_dtm[grant], p_s_vld=s_vld[grant], s_rdy[grant]=p_s_rdy. All other s_rdy=0.
  - On a transfer of a non-digit byte (the delimiter, which is forwarded to the parser), go to DRAIN.
- DRAIN:
  - All s_rdy=0, p_s_vld=0.
  - n_vld=p_n_vld, p_n_rdy=n_rdy, n_id=grant.
  - On p_n_vld&&n_rdy: rr_ptr<=(grant+1) mod N_CH, then go to IDLE.
- Outside DRAIN: n_vld=0 and p_n_rdy=0, except in the FLUSH states as stated above.
- Fairness: the rr_ptr rotation guarantees each digit-presenting channel is granted within N_CH numbers.
- Word width: the 32-bit number passes through unmodified. Overflow wraps inside the parser and is not this block's concern.
- Reset mid-operation (any state): controller returns to FLUSH; a partial number in the parser is terminated by 0x20 and discarded.
- Stall: the owner may stall indefinitely in LOCKED. There is no timeout unless the optional feature is enabled.

Optional Feature:
Macro NUM_ARB_TIMEOUT_EN.
- Enabled:
  - In LOCKED, timer counts cycles with s_vld[grant]=0 and clears on any owner transfer.
  - When timer reaches TIMEOUT_CYC-1, drive p_s_dtm=0x20, p_s_vld=1, s_rdy[grant]=0 until p_s_rdy. That transfer counts as the delimiter; go to DRAIN.
  - timer clears on entry to LOCKED and on reset.
- Disabled: no timer logic is present and LOCKED waits forever.

Test Plan:
- Reset flush: hold parser in READ_DIGITS (feed "12" before rst), pulse rst 1 cycle -> 0x20 sent, parser number discarded, n_vld stays 0, IDLE reached within 4 cycles of parser readiness.
- Single channel: ch1 sends "  42\n" -> two spaces dropped; n_dtm=42, n_id=1, n_vld=1; "\n" forwarded to parser as delimiter.
- Round robin: ch0 and ch2 both present "7," continuously, n_rdy=1 -> outputs alternate n_id=0,2,0,2, each with n_dtm=7.
- Non-digit drop during lock: ch0 locked on "123;", ch3 sends "ab5;" concurrently -> ch3 stays stalled (s_rdy[3]=0) until ch0 number 123 is taken; then ch3 yields 5 with n_id=3. "ab" is dropped only when ch3 is seen in IDLE.
- Back-pressure: hold n_rdy=0 for 20 cycles in DRAIN -> n_vld held, n_dtm/n_id stable, all s_rdy=0; release -> one transfer, then IDLE.
- Timeout (NUM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): ch1 sends "99" then idles -> 0x20 injected after 8 idle cycles; n_dtm=99, n_id=1.
